// File: rtl/mpsoc_msp430_trace_arb_pkg.sv
// Shared types and helpers for the MSP430 trace arbiter.
// A trace record is one retired instruction with its write-back.
package mpsoc_msp430_trace_arb_pkg;

    localparam int DROP_CNT_W = 16;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] insn;
        logic        wben;
        logic [4:0]  wbreg;
        logic [31:0] wbdata;
    } trace_rec_t;

    function automatic int next_rr(input int grant, input int num_ports);
        return (grant + 1 >= num_ports) ? 0 : grant + 1;
    endfunction

endpackage

// File: rtl/mpsoc_msp430_trace_fifo.sv
// Per-port trace record FIFO; a full FIFO still accepts a push
// when it pops in the same cycle.
module mpsoc_msp430_trace_fifo
    import mpsoc_msp430_trace_arb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  trace_rec_t push_rec,
    input  logic       pop,
    output trace_rec_t pop_rec,
    output logic       full,
    output logic       empty
);

    localparam int AW = $clog2(DEPTH);

    trace_rec_t      mem [DEPTH];
    logic [AW:0]     wr_ptr;
    logic [AW:0]     rd_ptr;
    logic            do_push;
    logic            do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign pop_rec = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr[AW-1:0]] <= push_rec;
    end

endmodule

// File: rtl/mpsoc_msp430_trace_arbiter.sv
// Round-robin merge of per-core trace streams into one tagged
// valid/ready channel, with drop statistics for full FIFOs.
module mpsoc_msp430_trace_arbiter
    import mpsoc_msp430_trace_arb_pkg::*;
#(
    parameter int NUM_PORTS  = 8,
    parameter int FIFO_DEPTH = 2,
    parameter int ID_W       = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_PORTS-1:0]    trace_valid,
    input  logic [NUM_PORTS*32-1:0] trace_pc,
    input  logic [NUM_PORTS*32-1:0] trace_insn,
    input  logic [NUM_PORTS-1:0]    trace_wben,
    input  logic [NUM_PORTS*5-1:0]  trace_wbreg,
    input  logic [NUM_PORTS*32-1:0] trace_wbdata,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [ID_W-1:0]         out_id,
    output logic [31:0]             out_pc,
    output logic [31:0]             out_insn,
    output logic                    out_wben,
    output logic [4:0]              out_wbreg,
    output logic [31:0]             out_wbdata,
    output logic [NUM_PORTS-1:0]    overflow,
    output logic [DROP_CNT_W-1:0]   drop_count,
    input  logic                    clear_stats
);

    trace_rec_t             in_rec  [NUM_PORTS];
    trace_rec_t             fifo_rec[NUM_PORTS];
    logic [NUM_PORTS-1:0]   full;
    logic [NUM_PORTS-1:0]   empty;
    logic [NUM_PORTS-1:0]   pop;
    logic [NUM_PORTS-1:0]   drop;
    logic [ID_W-1:0]        rr_ptr;
    logic [ID_W-1:0]        grant_id;
    logic                   grant_valid;
    logic                   load;
    trace_rec_t             out_rec;
    logic [31:0]            n_drops;
    logic [31:0]            drop_sum;
    logic [DROP_CNT_W-1:0]  drop_next;

    for (genvar k = 0; k < NUM_PORTS; k++) begin : g_port
        assign in_rec[k] = '{
            pc:     trace_pc[32*k +: 32],
            insn:   trace_insn[32*k +: 32],
            wben:   trace_wben[k],
            wbreg:  trace_wbreg[5*k +: 5],
            wbdata: trace_wbdata[32*k +: 32]
        };

        mpsoc_msp430_trace_fifo #(
            .DEPTH    (FIFO_DEPTH)
        ) u_fifo (
            .clk      (clk),
            .rst      (rst),
            .push     (trace_valid[k]),
            .push_rec (in_rec[k]),
            .pop      (pop[k]),
            .pop_rec  (fifo_rec[k]),
            .full     (full[k]),
            .empty    (empty[k])
        );
    end

    // First non-empty port at or above rr_ptr, wrapping around.
    always_comb begin
        int j;
        grant_valid = 1'b0;
        grant_id    = '0;
        j           = 0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            j = int'(rr_ptr) + i;
            if (j >= NUM_PORTS)
                j = j - NUM_PORTS;
            if (!grant_valid && !empty[ID_W'(j)]) begin
                grant_valid = 1'b1;
                grant_id    = ID_W'(j);
            end
        end
    end

    assign load = !out_valid || out_ready;

    always_comb begin
        pop      = '0;
        drop     = '0;
        n_drops  = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            pop[k]  = load && grant_valid && (grant_id == ID_W'(k));
            drop[k] = trace_valid[k] && full[k] && !pop[k];
            n_drops = n_drops + 32'(drop[k]);
        end
        drop_sum  = 32'(drop_count) + n_drops;
        drop_next = (|drop_sum[31:DROP_CNT_W]) ? '1
                                               : drop_sum[DROP_CNT_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_id    <= '0;
            out_rec   <= '0;
            rr_ptr    <= '0;
        end else if (load) begin
            out_valid <= grant_valid;
            if (grant_valid) begin
                out_id  <= grant_id;
                out_rec <= fifo_rec[grant_id];
                rr_ptr  <= ID_W'(next_rr(int'(grant_id), NUM_PORTS));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear_stats) begin
            overflow   <= '0;
            drop_count <= '0;
        end else begin
            overflow   <= overflow | drop;
            drop_count <= drop_next;
        end
    end

    assign out_pc     = out_rec.pc;
    assign out_insn   = out_rec.insn;
    assign out_wben   = out_rec.wben;
    assign out_wbreg  = out_rec.wbreg;
    assign out_wbdata = out_rec.wbdata;

endmodule

// File: tb/tb_mpsoc_msp430_trace_arbiter.sv
// Directed bench for the trace arbiter: latency, fairness, stalls,
// overflow, drop-counter saturation, clear and mid-run reset.
module tb_mpsoc_msp430_trace_arbiter;

    localparam int N = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   trace_valid;
    logic [N*32-1:0] trace_pc;
    logic [N*32-1:0] trace_insn;
    logic [N-1:0]   trace_wben;
    logic [N*5-1:0] trace_wbreg;
    logic [N*32-1:0] trace_wbdata;
    logic           out_valid;
    logic           out_ready;
    logic [2:0]     out_id;
    logic [31:0]    out_pc;
    logic [31:0]    out_insn;
    logic           out_wben;
    logic [4:0]     out_wbreg;
    logic [31:0]    out_wbdata;
    logic [N-1:0]   overflow;
    logic [15:0]    drop_count;
    logic           clear_stats;

    int tests = 0;
    int fails = 0;

    mpsoc_msp430_trace_arbiter #(
        .NUM_PORTS    (N),
        .FIFO_DEPTH   (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .trace_valid  (trace_valid),
        .trace_pc     (trace_pc),
        .trace_insn   (trace_insn),
        .trace_wben   (trace_wben),
        .trace_wbreg  (trace_wbreg),
        .trace_wbdata (trace_wbdata),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_id       (out_id),
        .out_pc       (out_pc),
        .out_insn     (out_insn),
        .out_wben     (out_wben),
        .out_wbreg    (out_wbreg),
        .out_wbdata   (out_wbdata),
        .overflow     (overflow),
        .drop_count   (drop_count),
        .clear_stats  (clear_stats)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic strobe(input int k, input logic [31:0] pc);
        trace_valid[k]           = 1'b1;
        trace_pc[32*k +: 32]     = pc;
        trace_insn[32*k +: 32]   = ~pc;
        trace_wben[k]            = 1'b1;
        trace_wbreg[5*k +: 5]    = 5'(k);
        trace_wbdata[32*k +: 32] = pc + 32'd1;
    endtask

    task automatic idle;
        trace_valid = '0;
    endtask

    task automatic do_reset;
        rst         = 1'b1;
        clear_stats = 1'b0;
        idle();
        step();
        rst = 1'b0;
    endtask

    initial begin
        trace_valid  = '0;
        trace_pc     = '0;
        trace_insn   = '0;
        trace_wben   = '0;
        trace_wbreg  = '0;
        trace_wbdata = '0;
        out_ready    = 1'b1;
        clear_stats  = 1'b0;
        rst          = 1'b1;
        step();
        do_reset();

        // reset state
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_id", 32'(out_id), 32'd0);
        check("rst_pc", out_pc, 32'd0);
        check("rst_insn", out_insn, 32'd0);
        check("rst_wbdata", out_wbdata, 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_drop", 32'(drop_count), 32'd0);

        // single record on port 3: visible two cycles later
        strobe(3, 32'h0000_1000);
        step();
        idle();
        check("lat_c1_valid", 32'(out_valid), 32'd0);
        step();
        check("lat_c2_valid", 32'(out_valid), 32'd1);
        check("lat_c2_id", 32'(out_id), 32'd3);
        check("lat_c2_pc", out_pc, 32'h0000_1000);
        check("lat_c2_insn", out_insn, 32'hFFFF_EFFF);
        check("lat_c2_wben", 32'(out_wben), 32'd1);
        check("lat_c2_wbreg", 32'(out_wbreg), 32'd3);
        check("lat_c2_wbdata", out_wbdata, 32'h0000_1001);
        step();
        check("lat_c3_valid", 32'(out_valid), 32'd0);
        check("lat_c3_pc_hold", out_pc, 32'h0000_1000);

        // all ports at once, then port 0 again mid-burst
        do_reset();
        for (int k = 0; k < N; k++)
            strobe(k, 32'h2000 + 32'(k * 16));
        step();
        idle();
        step();
        for (int i = 0; i < N; i++) begin
            if (i == 0)
                strobe(0, 32'h0000_ABC0);
            check("rr_valid", 32'(out_valid), 32'd1);
            check("rr_id", 32'(out_id), 32'(i));
            check("rr_pc", out_pc, 32'h2000 + 32'(i * 16));
            step();
            idle();
        end
        check("rr_wrap_valid", 32'(out_valid), 32'd1);
        check("rr_wrap_id", 32'(out_id), 32'd0);
        check("rr_wrap_pc", out_pc, 32'h0000_ABC0);
        step();
        check("rr_end_valid", 32'(out_valid), 32'd0);

        // stall with port 1 overflowing behind a held record
        do_reset();
        out_ready = 1'b0;
        strobe(0, 32'h3000);
        step();
        idle();
        strobe(1, 32'h3100);
        step();
        strobe(1, 32'h3104);
        check("stall_c2_valid", 32'(out_valid), 32'd1);
        check("stall_c2_id", 32'(out_id), 32'd0);
        check("stall_c2_pc", out_pc, 32'h3000);
        step();
        idle();
        strobe(1, 32'h3108);
        step();
        idle();
        check("stall_ovf", 32'(overflow), 32'h02);
        check("stall_drop", 32'(drop_count), 32'd1);
        check("stall_hold_valid", 32'(out_valid), 32'd1);
        check("stall_hold_id", 32'(out_id), 32'd0);
        check("stall_hold_pc", out_pc, 32'h3000);
        out_ready = 1'b1;
        step();
        check("stall_r1_id", 32'(out_id), 32'd1);
        check("stall_r1_pc", out_pc, 32'h3100);
        step();
        check("stall_r2_id", 32'(out_id), 32'd1);
        check("stall_r2_pc", out_pc, 32'h3104);
        step();
        check("stall_end_valid", 32'(out_valid), 32'd0);
        check("stall_ovf_sticky", 32'(overflow), 32'h02);

        // full FIFO pushed while being popped: no drop
        do_reset();
        out_ready = 1'b0;
        strobe(2, 32'h4000);
        step();
        strobe(2, 32'h4010);
        step();
        strobe(2, 32'h4020);
        step();
        out_ready = 1'b1;
        strobe(2, 32'h4030);
        check("pp_c3_pc", out_pc, 32'h4000);
        step();
        idle();
        check("pp_ovf", 32'(overflow), 32'd0);
        check("pp_drop", 32'(drop_count), 32'd0);
        check("pp_r1_id", 32'(out_id), 32'd2);
        check("pp_r1_pc", out_pc, 32'h4010);
        step();
        check("pp_r2_pc", out_pc, 32'h4020);
        step();
        check("pp_r3_pc", out_pc, 32'h4030);
        check("pp_r3_valid", 32'(out_valid), 32'd1);
        step();
        check("pp_end_valid", 32'(out_valid), 32'd0);

        // drop counter: 7 drops at edge 3, then 8 per cycle
        do_reset();
        out_ready = 1'b0;
        for (int k = 0; k < N; k++)
            strobe(k, 32'h5000 + 32'(k));
        repeat (4) step();
        check("sat_early_drop", 32'(drop_count), 32'd15);
        check("sat_early_ovf", 32'(overflow), 32'hFF);
        repeat (9000) step();
        check("sat_drop", 32'(drop_count), 32'h0000_FFFF);
        clear_stats = 1'b1;
        step();
        clear_stats = 1'b0;
        check("clr_drop", 32'(drop_count), 32'd0);
        check("clr_ovf", 32'(overflow), 32'd0);
        step();
        idle();
        check("clr_resume_drop", 32'(drop_count), 32'd8);
        check("clr_resume_ovf", 32'(overflow), 32'hFF);

        // reset with buffered records and a valid output
        do_reset();
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++)
            strobe(k, 32'h6000 + 32'(k));
        step();
        idle();
        strobe(1, 32'h6100);
        step();
        strobe(1, 32'h6200);
        step();
        idle();
        check("mr_pre_drop", 32'(drop_count), 32'd1);
        check("mr_pre_valid", 32'(out_valid), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mr_valid", 32'(out_valid), 32'd0);
        check("mr_drop", 32'(drop_count), 32'd0);
        check("mr_ovf", 32'(overflow), 32'd0);
        check("mr_pc", out_pc, 32'd0);
        out_ready = 1'b1;
        repeat (6) begin
            step();
            check("mr_no_stale", 32'(out_valid), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
